keypad_scanner_4x4: RTL and testbench

//  Scans a 4x4 matrix keypad and reports debounced key presses. Consumes the 1 kHz single-cycle strobe from
//  the slow-clock tick generator; drives one column low per step, reads the rows and confirms a press by

---
 rtl/keypad_scanner_4x4_if.sv | 28 ++
 rtl/keypad_scanner_4x4.sv | 148 ++++++++++++++
 tb/tb_keypad_scanner_4x4.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_4x4_if.sv
// Signal bundle between the keypad scanner and the keypad/decoder side.
// The master modport is the scanner; the slave modport is the keypad model or consumer.
interface keypad_scanner_4x4_if;
    logic       tick_in;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  tick_in,
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output tick_in,
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: one column driven low per tick, debounced press/release,
// single-cycle key_valid pulse on press confirmation and key_down level while held.
//
// state       | meaning
// ST_SCAN     | rotating columns, looking for any low row on the driven column
// ST_DEBOUNCE | column frozen, counting consecutive ticks with the latched row low
// ST_HELD     | key confirmed, column frozen, counting consecutive ticks with the row high
module keypad_scanner_4x4 #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int CNT_W          = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    keypad_scanner_4x4_if.master  kp
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS);

    state_t           state, state_nxt;
    logic [3:0]       sync_1, rs;
    logic [1:0]       col_sel, col_nxt;
    logic [3:0]       col_q, col_q_nxt;
    logic [1:0]       row_sel, row_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]       code_q, code_nxt;
    logic             valid_q, valid_nxt;
    logic             down_q, down_nxt;
    logic             row_low;

    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    // row_in is asynchronous to clk_in; only the second stage is used for decisions
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_1 <= 4'hF;
            rs     <= 4'hF;
        end else begin
            sync_1 <= kp.row_in;
            rs     <= sync_1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= ST_SCAN;
            col_sel <= 2'd0;
            col_q   <= 4'b1110;
            row_sel <= 2'd0;
            cnt     <= '0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            col_sel <= col_nxt;
            col_q   <= col_q_nxt;
            row_sel <= row_nxt;
            cnt     <= cnt_nxt;
            code_q  <= code_nxt;
            valid_q <= valid_nxt;
            down_q  <= down_nxt;
        end
    end

    assign row_low = ~rs[row_sel];
    assign cnt_inc = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        col_nxt   = col_sel;
        row_nxt   = row_sel;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        valid_nxt = 1'b0;
        down_nxt  = down_q;

        if (kp.tick_in) begin
            case (state)
                ST_SCAN: begin
                    if (rs == 4'hF) begin
                        col_nxt = col_sel + 2'd1;
                    end else begin
                        row_nxt   = lowest_low(rs);
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_low) begin
                        if (cnt_inc >= CNT_MAX) begin
                            code_nxt  = {row_sel, col_sel};
                            down_nxt  = 1'b1;
                            valid_nxt = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = ST_HELD;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        col_nxt   = col_sel + 2'd1;
                        state_nxt = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // any low sample restarts the release count, so chatter cannot release early
                    if (row_low) begin
                        cnt_nxt = '0;
                    end else if (cnt_inc >= CNT_MAX) begin
                        down_nxt  = 1'b0;
                        cnt_nxt   = '0;
                        col_nxt   = col_sel + 2'd1;
                        state_nxt = ST_SCAN;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = ST_SCAN;
                    col_nxt   = 2'd0;
                    cnt_nxt   = '0;
                    down_nxt  = 1'b0;
                end
            endcase
        end

        col_q_nxt = ~(4'b0001 << col_nxt);
    end

    assign kp.col_out   = col_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4: a keypad model drives rows from the pressed-key
// mask and the driven column; a step table plus hand-written reset/tick sequences.
module tb_keypad_scanner_4x4;

    logic clk_in = 1'b0;
    logic rst;
    always #5 clk_in = ~clk_in;

    keypad_scanner_4x4_if kp();

    keypad_scanner_4x4 #(.DEBOUNCE_TICKS(20), .CNT_W(8)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .kp     (kp)
    );

    // pressed keys, bit index = row*4 + col
    logic [15:0] keys;

    always_comb begin
        logic [3:0] row;
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.col_out[c]) row[r] = 1'b0;
        kp.row_in = row;
    end

    int   valid_cnt   = 0;
    int   double_vld  = 0;
    logic prev_valid  = 1'b0;

    always @(negedge clk_in) begin
        if (kp.key_valid) begin
            valid_cnt++;
            if (prev_valid) double_vld++;
        end
        prev_valid = kp.key_valid;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        repeat (3) @(negedge clk_in);
        kp.tick_in = 1'b1;
        @(negedge clk_in);
        kp.tick_in = 1'b0;
    endtask

    typedef struct {
        logic [15:0] keys;
        int          n;
        logic [3:0]  col;
        logic        down;
        logic [3:0]  code;
        int          nv;
    } step_t;

    step_t steps[$];

    function automatic void add(input logic [15:0] k, input int n, input logic [3:0] c,
                                input logic d, input logic [3:0] code, input int nv);
        step_t s;
        s.keys = k; s.n = n; s.col = c; s.down = d; s.code = code; s.nv = nv;
        steps.push_back(s);
    endfunction

    initial begin
        int v0;

        // idle rotation
        add(16'h0000, 1, 4'hD, 0, 4'h0, 0);
        add(16'h0000, 1, 4'hB, 0, 4'h0, 0);
        add(16'h0000, 1, 4'h7, 0, 4'h0, 0);
        add(16'h0000, 1, 4'hE, 0, 4'h0, 0);
        add(16'h0000, 1, 4'hD, 0, 4'h0, 0);
        add(16'h0000, 1, 4'hB, 0, 4'h0, 0);
        add(16'h0000, 1, 4'h7, 0, 4'h0, 0);
        add(16'h0000, 1, 4'hE, 0, 4'h0, 0);
        // clean press row2/col1, then release
        add(16'h0200, 1, 4'hD, 0, 4'h0, 0);
        add(16'h0200, 1, 4'hD, 0, 4'h0, 0);
        add(16'h0200, 18, 4'hD, 0, 4'h0, 0);
        add(16'h0200, 1, 4'hD, 1, 4'h9, 1);
        add(16'h0200, 19, 4'hD, 1, 4'h9, 0);
        add(16'h0000, 19, 4'hD, 1, 4'h9, 0);
        add(16'h0000, 1, 4'hB, 0, 4'h9, 0);
        // bounce on row0/col3
        add(16'h0008, 1, 4'h7, 0, 4'h9, 0);
        add(16'h0008, 5, 4'h7, 0, 4'h9, 0);
        add(16'h0000, 1, 4'hE, 0, 4'h9, 0);
        // two rows on col0, row1 wins; col3 key while held is ignored
        add(16'h1010, 1, 4'hE, 0, 4'h9, 0);
        add(16'h1010, 18, 4'hE, 0, 4'h9, 0);
        add(16'h1010, 1, 4'hE, 1, 4'h4, 1);
        add(16'h1810, 10, 4'hE, 1, 4'h4, 0);
        // release chatter
        add(16'h0000, 10, 4'hE, 1, 4'h4, 0);
        add(16'h0010, 1, 4'hE, 1, 4'h4, 0);
        add(16'h0000, 10, 4'hE, 1, 4'h4, 0);
        add(16'h0010, 1, 4'hE, 1, 4'h4, 0);
        add(16'h0000, 19, 4'hE, 1, 4'h4, 0);
        add(16'h0000, 1, 4'hD, 0, 4'h4, 0);

        rst        = 1'b1;
        kp.tick_in = 1'b0;
        keys       = 16'h0000;
        repeat (3) @(negedge clk_in);
        check("reset col_out",   kp.col_out,   4'hE);
        check("reset key_code",  kp.key_code,  4'h0);
        check("reset key_valid", kp.key_valid, 1'b0);
        check("reset key_down",  kp.key_down,  1'b0);
        rst = 1'b0;

        foreach (steps[i]) begin
            keys = steps[i].keys;
            v0   = valid_cnt;
            repeat (steps[i].n) tick();
            repeat (2) @(negedge clk_in);
            check($sformatf("step%0d col_out", i),  kp.col_out,     steps[i].col);
            check($sformatf("step%0d key_down", i), kp.key_down,    steps[i].down);
            check($sformatf("step%0d key_code", i), kp.key_code,    steps[i].code);
            check($sformatf("step%0d valid_n", i),  valid_cnt - v0, steps[i].nv);
        end

        // reset mid-debounce, asserted between clock edges
        keys = 16'h0002;
        repeat (6) tick();
        repeat (2) @(negedge clk_in);
        check("debounce col_out", kp.col_out, 4'hD);
        #2 rst = 1'b1;
        #1;
        check("rst_deb col_out",   kp.col_out,   4'hE);
        check("rst_deb key_code",  kp.key_code,  4'h0);
        check("rst_deb key_down",  kp.key_down,  1'b0);
        check("rst_deb key_valid", kp.key_valid, 1'b0);
        @(negedge clk_in);
        rst  = 1'b0;
        keys = 16'h0000;
        v0   = valid_cnt;
        repeat (4) tick();
        repeat (2) @(negedge clk_in);
        check("post_rst col_out", kp.col_out,     4'hE);
        check("post_rst valid_n", valid_cnt - v0, 0);

        // press row2/col0 into HELD, then reset mid-held
        keys = 16'h0100;
        v0   = valid_cnt;
        repeat (20) tick();
        repeat (2) @(negedge clk_in);
        check("held key_down", kp.key_down,     1'b1);
        check("held key_code", kp.key_code,     4'h8);
        check("held valid_n",  valid_cnt - v0,  1);
        #2 rst = 1'b1;
        #1;
        check("rst_held col_out",  kp.col_out,  4'hE);
        check("rst_held key_code", kp.key_code, 4'h0);
        check("rst_held key_down", kp.key_down, 1'b0);
        @(negedge clk_in);
        rst  = 1'b0;
        keys = 16'h0000;

        // tick high on two consecutive cycles counts twice
        repeat (3) @(negedge clk_in);
        kp.tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        kp.tick_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("double_tick col_out", kp.col_out, 4'hB);

        check("key_valid back_to_back", double_vld, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
